// File: rtl/fight_pkg.sv
// Shared gameplay constants: attack-type codes, PS/2 prefix bytes and the
// scan-code parser state encoding.
package fight_pkg;

  localparam logic [3:0] STANDBY = 4'b0000;
  localparam logic [3:0] LIGHT   = 4'b0001;
  localparam logic [3:0] HEAVY   = 4'b0010;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BRK     = 2'd1;
  localparam logic [1:0] EXT     = 2'd2;
  localparam logic [1:0] EXT_BRK = 2'd3;

endpackage

// File: rtl/cooldown_timer.sv
// Saturating down-counter with a load strobe; o_busy is registered alongside
// the count so it is exactly (count != 0).
module cooldown_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_busy
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load)
      w_cnt_nxt = i_load_val;
    else if (r_cnt != '0)
      w_cnt_nxt = r_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
    end
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/attack_key_decoder.sv
// PS/2 scan-code stream to one-cycle attack command, with typematic filtering
// and cooldown. Define ATTACK_QUEUE_EN to hold one attack made during cooldown.
module attack_key_decoder
  import fight_pkg::*;
#(
  parameter logic [7:0]  KEY_LIGHT = 8'h1C,
  parameter logic [7:0]  KEY_HEAVY = 8'h1B,
  parameter int unsigned CD_LIGHT  = 5_000_000,
  parameter int unsigned CD_HEAVY  = 10_000_000,
  parameter int          CNT_W     = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_code,
  input  logic       scan_valid,
  output logic [3:0] attack_type,
  output logic       attack_valid,
  output logic       cooldown_busy,
  output logic [1:0] key_held
);

  logic [1:0]       r_state;
  logic [1:0]       r_key_held;
  logic [3:0]       r_attack_type;
  logic             r_attack_valid;

  logic             w_busy;
  logic             w_is_make;
  logic             w_fresh_l;
  logic             w_fresh_h;
  logic             w_fresh;
  logic             w_issue;
  logic [3:0]       w_issue_type;
  logic [CNT_W-1:0] w_load_val;

  // Only a make in IDLE on a key not already down counts; repeats are dropped.
  always_comb begin
    w_is_make = scan_valid && (r_state == IDLE) &&
                (scan_code != SC_BREAK) && (scan_code != SC_EXT);
    w_fresh_l = w_is_make && (scan_code == KEY_LIGHT) && !r_key_held[0];
    w_fresh_h = w_is_make && (scan_code == KEY_HEAVY) && !r_key_held[1];
    w_fresh   = w_fresh_l || w_fresh_h;
  end

`ifdef ATTACK_QUEUE_EN
  logic r_pend_vld;
  logic r_pend_heavy;
  logic w_issue_new;

  always_comb begin
    w_issue_new  = w_fresh && !w_busy;
    w_issue      = w_issue_new || (r_pend_vld && !w_busy);
    w_issue_type = w_issue_new ? (w_fresh_h ? HEAVY : LIGHT)
                               : (r_pend_heavy ? HEAVY : LIGHT);
  end

  // Newest blocked make wins; the slot empties whenever anything issues.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend_vld   <= 1'b0;
      r_pend_heavy <= 1'b0;
    end else if (w_fresh && w_busy) begin
      r_pend_vld   <= 1'b1;
      r_pend_heavy <= w_fresh_h;
    end else if (w_issue) begin
      r_pend_vld   <= 1'b0;
    end
  end
`else
  always_comb begin
    w_issue      = w_fresh && !w_busy;
    w_issue_type = w_fresh_h ? HEAVY : LIGHT;
  end
`endif

  assign w_load_val = (w_issue_type == HEAVY) ? CNT_W'(CD_HEAVY) : CNT_W'(CD_LIGHT);

  cooldown_timer #(.CNT_W(CNT_W)) u_cd (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_issue),
    .i_load_val (w_load_val),
    .o_busy     (w_busy)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= IDLE;
      r_key_held     <= 2'b00;
      r_attack_type  <= STANDBY;
      r_attack_valid <= 1'b0;
    end else begin
      r_attack_type  <= w_issue ? w_issue_type : STANDBY;
      r_attack_valid <= w_issue;
      if (w_fresh_l) r_key_held[0] <= 1'b1;
      if (w_fresh_h) r_key_held[1] <= 1'b1;
      if (scan_valid) begin
        case (r_state)
          IDLE: begin
            if (scan_code == SC_BREAK)    r_state <= BRK;
            else if (scan_code == SC_EXT) r_state <= EXT;
          end
          BRK: begin
            if (scan_code == KEY_LIGHT) r_key_held[0] <= 1'b0;
            if (scan_code == KEY_HEAVY) r_key_held[1] <= 1'b0;
            r_state <= IDLE;
          end
          EXT:     r_state <= (scan_code == SC_BREAK) ? EXT_BRK : IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign attack_type   = r_attack_type;
  assign attack_valid  = r_attack_valid;
  assign cooldown_busy = w_busy;
  assign key_held      = r_key_held;

endmodule

// File: tb/tb_attack_key_decoder.sv
// Bench for attack_key_decoder: directed scenarios plus random byte streams,
// all checked cycle by cycle against a sequence-level reference model.
module tb_attack_key_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [3:0] attack_type;
  logic       attack_valid;
  logic       cooldown_busy;
  logic [1:0] key_held;

  always #5 clk = ~clk;

  attack_key_decoder #(
    .KEY_LIGHT (8'h1C),
    .KEY_HEAVY (8'h1B),
    .CD_LIGHT  (8),
    .CD_HEAVY  (16),
    .CNT_W     (24)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .scan_code     (scan_code),
    .scan_valid    (scan_valid),
    .attack_type   (attack_type),
    .attack_valid  (attack_valid),
    .cooldown_busy (cooldown_busy),
    .key_held      (key_held)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: bytes collect into a sequence that is interpreted once
  // complete; cooldown is "cycles since last issue" rather than a counter.
  logic [7:0] seq[$];
  bit   [1:0] m_held;
  bit         m_has, m_iss, m_iss_heavy, m_pend, m_pend_heavy;
  int         m_last, m_cd;
  int         cyc = 0;
  int         n_valid = 0, last_vcyc = 0, prev_vcyc = 0;

  task automatic m_issue(input bit heavy, input int k);
    m_iss       = 1'b1;
    m_iss_heavy = heavy;
    m_has       = 1'b1;
    m_last      = k;
    m_cd        = heavy ? 16 : 8;
  endtask

  task automatic step(input bit rn, input bit v, input logic [7:0] b);
    bit busy_prev, fresh, fh, done, exp_busy;
    int k;
    reset = rn; scan_valid = v; scan_code = b;
    @(posedge clk);
    cyc++;
    k = cyc;
    m_iss = 1'b0;
    if (!rn) begin
      m_held = 2'b00; m_has = 1'b0; m_pend = 1'b0;
      seq.delete();
    end else begin
      busy_prev = m_has && (k <= m_last + m_cd);
      fresh = 1'b0; fh = 1'b0;
      if (v) begin
        seq.push_back(b);
        done = (seq.size() == 3) ||
               (seq.size() == 1 && b != 8'hF0 && b != 8'hE0) ||
               (seq.size() == 2 && (seq[0] == 8'hF0 || b != 8'hF0));
        if (done) begin
          if (seq.size() == 1) begin
            if (b == 8'h1C && !m_held[0]) begin m_held[0] = 1'b1; fresh = 1'b1; fh = 1'b0; end
            if (b == 8'h1B && !m_held[1]) begin m_held[1] = 1'b1; fresh = 1'b1; fh = 1'b1; end
          end else if (seq.size() == 2 && seq[0] == 8'hF0) begin
            if (b == 8'h1C) m_held[0] = 1'b0;
            if (b == 8'h1B) m_held[1] = 1'b0;
          end
          seq.delete();
        end
      end
      if (fresh && !busy_prev) begin
        m_issue(fh, k);
        m_pend = 1'b0;
      end else if (fresh) begin
`ifdef ATTACK_QUEUE_EN
        m_pend = 1'b1;
        m_pend_heavy = fh;
`endif
      end else if (m_pend && !busy_prev) begin
        m_issue(m_pend_heavy, k);
        m_pend = 1'b0;
      end
    end
    #1;
    exp_busy = m_has && (k < m_last + m_cd);
    chk($sformatf("outs@%0d", k),
        {attack_type, attack_valid, cooldown_busy, key_held},
        {(m_iss ? (m_iss_heavy ? 4'd2 : 4'd1) : 4'd0), m_iss, exp_busy, m_held});
    if (attack_valid) begin
      n_valid++;
      prev_vcyc = last_vcyc;
      last_vcyc = k;
    end
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  int n0, bc, exp_n;

  initial begin
    reset = 1'b0; scan_valid = 1'b0; scan_code = 8'h00;
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Reset held through an active cooldown, then immediate re-issue
    send(8'h1C); idle(3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h1C);
    chk("rst_busy", cooldown_busy, 1'b0);
    send(8'h1C);
    chk("rst_reissue", attack_valid, 1'b1);
    send(8'hF0); send(8'h1C); idle(20);

    // Light attack and cooldown length
    send(8'h1C);
    chk("light_type", attack_type, 4'b0001);
    bc = cooldown_busy;
    for (int i = 0; i < 12; i++) begin idle(1); bc += cooldown_busy; end
    chk("light_busy_len", bc, 8);
    send(8'hF0); send(8'h1C); idle(20);

    // Typematic repeat
    n0 = n_valid;
    send(8'h1C); idle(20); send(8'h1C); idle(20); send(8'h1C); idle(20);
    chk("typematic_one", n_valid - n0, 1);
    send(8'hF0); send(8'h1C); send(8'h1C); idle(20);
    chk("typematic_two", n_valid - n0, 2);
    send(8'hF0); send(8'h1C); idle(20);

    // Cooldown drop / queue
    n0 = n_valid;
    send(8'h1B); send(8'hF0); send(8'h1B); idle(7); send(8'h1B); idle(20);
`ifdef ATTACK_QUEUE_EN
    exp_n = 2;
    chk("cd_queue_lat", last_vcyc - prev_vcyc, 17);
`else
    exp_n = 1;
`endif
    chk("cd_drop_count", n_valid - n0, exp_n);
    send(8'hF0); send(8'h1B); idle(20);

    // Extended keys never attack
    n0 = n_valid;
    send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C); idle(3);
    chk("ext_no_attack", n_valid - n0, 0);
    chk("ext_held", key_held, 2'b00);
    send(8'h1C);
    chk("ext_idle_after", attack_valid, 1'b1);
    send(8'hF0); send(8'h1C); idle(20);

    // Boundary: make in the cycle the counter goes 1->0
    send(8'h1C); send(8'hF0); send(8'h1C); idle(5); send(8'h1C);
    chk("bnd_drop", attack_valid, 1'b0);
    idle(1);
`ifdef ATTACK_QUEUE_EN
    chk("bnd_queue", attack_valid, 1'b1);
`else
    chk("bnd_queue", attack_valid, 1'b0);
`endif
    send(8'hF0); send(8'h1C); idle(20);
    send(8'h1C); send(8'hF0); send(8'h1C); idle(6); send(8'h1C);
    chk("bnd_issue", attack_valid, 1'b1);
    send(8'hF0); send(8'h1C); idle(20);

    // Random streams
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      if (r < 3)       b = 8'h1C;
      else if (r < 6)  b = 8'h1B;
      else if (r == 6) b = 8'hF0;
      else if (r == 7) b = 8'hE0;
      else             b = 8'($urandom_range(0, 255));
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 2) == 0), b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
